// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter sharing one registered AND/OR/XOR/NOT
//               unit between two requesters, with a completed-op counter.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [1:0]       f0,
    input  logic             req1,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    input  logic [1:0]       f1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [W-1:0]     out,
    output logic             out_valid,
    output logic             out_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_EXEC = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    localparam logic [1:0] c_OP_AND = 2'd0;
    localparam logic [1:0] c_OP_OR  = 2'd1;
    localparam logic [1:0] c_OP_XOR = 2'd2;

    logic [1:0]       r_state;
    logic             r_last;
    logic             r_win;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [1:0]       r_f;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_done0;
    logic             r_done1;
    logic [W-1:0]     r_out;
    logic             r_out_valid;
    logic             r_out_id;
    logic             r_busy;
    logic [CNT_W-1:0] r_op_cnt;

    logic             w_any_req;
    logic             w_pick1;
    logic [W-1:0]     w_result;

    // Under contention the requester that was not served last wins.
    assign w_any_req = req0 | req1;
    assign w_pick1   = req1 & (~req0 | ~r_last);

    always_comb begin
        w_result = '0;
        case (r_f)
            c_OP_AND: w_result = r_a & r_b;
            c_OP_OR:  w_result = r_a | r_b;
            c_OP_XOR: w_result = r_a ^ r_b;
            default:  w_result = ~r_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_last      <= 1'b1;
            r_win       <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_f         <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_out_id    <= 1'b0;
            r_busy      <= 1'b0;
            r_op_cnt    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any_req) begin
                        r_win   <= w_pick1;
                        r_a     <= w_pick1 ? a1 : a0;
                        r_b     <= w_pick1 ? b1 : b0;
                        r_f     <= w_pick1 ? f1 : f0;
                        r_gnt0  <= ~w_pick1;
                        r_gnt1  <= w_pick1;
                        r_busy  <= 1'b1;
                        r_state <= c_ST_EXEC;
                    end
                end
                c_ST_EXEC: begin
                    r_out       <= w_result;
                    r_out_id    <= r_win;
                    r_out_valid <= 1'b1;
                    r_done0     <= ~r_win;
                    r_done1     <= r_win;
                    r_op_cnt    <= r_op_cnt + 1'b1;
                    r_state     <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    r_out_valid <= 1'b0;
                    r_done0     <= 1'b0;
                    r_done1     <= 1'b0;
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_last      <= r_win;
                    r_state     <= c_ST_IDLE;
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_done0     <= 1'b0;
                    r_done1     <= 1'b0;
                    r_gnt0      <= 1'b0;
                    r_gnt1      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign out_id    = r_out_id;
    assign busy      = r_busy;
    assign op_cnt    = r_op_cnt;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Scoreboard bench for logic_unit_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

    localparam int W     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [W-1:0]     a0, b0, a1, b1;
    logic [1:0]       f0, f1;
    logic             gnt0, gnt1, done0, done1;
    logic [W-1:0]     out;
    logic             out_valid, out_id, busy;
    logic [CNT_W-1:0] op_cnt;

    typedef struct packed {
        logic         id;
        logic [W-1:0] res;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic_unit_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .f0(f0),
        .req1(req1), .a1(a1), .b1(b1), .f1(f1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .out(out), .out_valid(out_valid), .out_id(out_id),
        .busy(busy), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] f);
        case (f)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Per-cycle protocol check plus scoreboard pop on every result.
    always @(negedge clk) begin
        check("exclusive", {29'd0, gnt0 & gnt1, done0 & done1, (done0 | done1) ^ out_valid}, 32'd0);
        if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("out", {28'd0, out}, {28'd0, e.res});
                check("out_id", {31'd0, out_id}, {31'd0, e.id});
                check("done_id", {30'd0, done1, done0}, e.id ? 32'd2 : 32'd1);
            end
        end
    end

    // Called at a negedge while idle; walks one operation cycle by cycle.
    task automatic single_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [1:0] f, input bit mutate);
        logic [31:0] g;
        g = id ? 32'd2 : 32'd1;
        if (id == 1'b0) begin
            a0 = a; b0 = b; f0 = f; req0 = 1'b1;
        end else begin
            a1 = a; b1 = b; f1 = f; req1 = 1'b1;
        end
        q.push_back(exp_t'{id: id, res: exp_op(a, b, f)});
        @(negedge clk);
        check("gnt", {30'd0, gnt1, gnt0}, g);
        check("busy_exec", {31'd0, busy}, 32'd1);
        check("done_early", {30'd0, done1, done0}, 32'd0);
        if (mutate) begin
            if (id == 1'b0) begin a0 = '1; req0 = 1'b0; end
            else            begin a1 = '1; req1 = 1'b0; end
        end
        @(negedge clk);
        check("done", {30'd0, done1, done0}, g);
        check("gnt_resp", {30'd0, gnt1, gnt0}, g);
        check("busy_resp", {31'd0, busy}, 32'd1);
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("idle", {29'd0, gnt1, gnt0, busy}, 32'd0);
    endtask

    initial begin
        int nd;
        logic [W-1:0] rb;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; f0 = '0; a1 = '0; b1 = '0; f1 = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {18'd0, gnt0, gnt1, done0, done1, out, out_valid, out_id, busy, op_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Requester 0 alone, every opcode.
        for (int f = 0; f < 4; f++) single_op(1'b0, 4'b0101, 4'b0011, f[1:0], 1'b0);
        check("t1_op_cnt", {24'd0, op_cnt}, 32'd4);

        // Both held from reset: strict alternation starting with 0.
        rst = 1'b1;
        a0 = 4'b0101; b0 = 4'b0011; f0 = 2'd2;
        a1 = 4'b1100; b1 = 4'b1010; f1 = 2'd1;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++)
            q.push_back(exp_t'{id: i[0], res: i[0] ? 4'b1110 : 4'b0110});
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 40 && nd < 4; i++) begin
            @(negedge clk);
            if (done0 | done1) nd++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("t2_done_count", nd, 32'd4);
        repeat (3) @(negedge clk);
        check("t2_drained", q.size(), 32'd0);

        // Requester 1 alone with NOT; b1 must not matter.
        rb = W'($urandom);
        single_op(1'b1, 4'b1100, rb, 2'd3, 1'b0);

        // Operands change and req drops after grant.
        single_op(1'b0, 4'b0101, 4'b0011, 2'd0, 1'b1);

        // Reset during EXEC discards the op; then requester 0 wins contention.
        a0 = 4'b0011; b0 = 4'b0101; f0 = 2'd1; req0 = 1'b1;
        @(negedge clk);
        check("t5_gnt_exec", {30'd0, gnt1, gnt0}, 32'd1);
        #1 rst = 1'b1;
        #1 check("t5_async_reset", {18'd0, gnt0, gnt1, done0, done1, out, out_valid, out_id, busy, op_cnt}, 32'd0);
        req1 = 1'b1; a1 = 4'b1111; b1 = 4'b0000; f1 = 2'd0;
        q.push_back(exp_t'{id: 1'b0, res: 4'b0111});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rr_after_reset", {30'd0, gnt1, gnt0}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_drained", q.size(), 32'd0);

        // Counter wrap: 255 back-to-back ops, then one more.
        rst = 1'b1;
        #1 rst = 1'b0;
        a0 = 4'b1010; b0 = 4'b0110; f0 = 2'd2; req0 = 1'b1;
        for (int i = 0; i < 255; i++) q.push_back(exp_t'{id: 1'b0, res: 4'b1100});
        nd = 0;
        for (int i = 0; i < 900 && nd < 255; i++) begin
            @(negedge clk);
            if (done0 | done1) begin
                nd++;
                if (nd == 255) check("t6_cnt_255", {24'd0, op_cnt}, 32'd255);
            end
        end
        req0 = 1'b0;
        check("t6_done_count", nd, 32'd255);
        @(negedge clk);
        single_op(1'b0, 4'b1001, 4'b0001, 2'd1, 1'b0);
        check("t6_cnt_wrap", {24'd0, op_cnt}, 32'd0);
        check("t6_drained", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
